// File: rtl/fixed_to_float_pipe.sv
// Three-stage pipelined converter from signed fixed-point to IEEE-754 single.
// Valid/ready handshake on both sides; RNE rounding for inputs wider than 24 bits.
module fixed_to_float_pipe #(
    parameter int unsigned WIDTH     = 22,
    parameter int unsigned FRAC_BITS = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fix_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      float_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       in_flight
);

    localparam int unsigned PW      = 5;
    localparam int          EXP_OFF = 127 - int'(FRAC_BITS);

    logic             s1_valid_q;
    logic             s1_sign_q;
    logic [WIDTH-1:0] s1_mag_q;
    logic             s2_valid_q;
    logic             s2_sign_q;
    logic [7:0]       s2_exp_q;
    logic [31:0]      s2_norm_q;
    logic             out_valid_q;
    logic [31:0]      float_q;

    logic             s3_en;
    logic             s2_move;
    logic             s1_move;
    logic             accept;
    logic [WIDTH-1:0] mag_d;
    logic [PW-1:0]    lead_p;
    logic [31:0]      norm_d;
    logic [7:0]       exp_d;
    logic             rnd;
    logic [23:0]      mant_r;
    logic             zero;
    logic [31:0]      result_d;

    // Each stage moves when its successor is empty or moving itself
    assign s3_en    = !out_valid_q || out_ready;
    assign s2_move  = s2_valid_q && s3_en;
    assign s1_move  = s1_valid_q && (!s2_valid_q || s2_move);
    assign in_ready = !s1_valid_q || s1_move;
    assign accept   = in_valid && in_ready;

    // Unsigned magnitude; the most negative input maps to 2^(WIDTH-1)
    assign mag_d = fix_in[WIDTH-1] ? -fix_in : fix_in;

    always_comb begin
        lead_p = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s1_mag_q[i]) begin
                lead_p = PW'(i);
            end
        end
    end

    assign norm_d = 32'(s1_mag_q) << (PW'(31) - lead_p);
    assign exp_d  = 8'(EXP_OFF + int'(lead_p));

    // Normalised leading one is absent only for a zero magnitude
    assign zero     = !s2_norm_q[31];
    assign rnd      = s2_norm_q[7] && (s2_norm_q[8] || (|s2_norm_q[6:0]));
    assign mant_r   = {1'b0, s2_norm_q[30:8]} + 24'(rnd);
    assign result_d = zero ? 32'd0
                           : {s2_sign_q, s2_exp_q + 8'(mant_r[23]), mant_r[22:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_norm_q   <= '0;
            out_valid_q <= 1'b0;
            float_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (accept) begin
                s1_sign_q <= fix_in[WIDTH-1];
                s1_mag_q  <= mag_d;
            end
            if (!s2_valid_q || s2_move) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s1_move) begin
                s2_sign_q <= s1_sign_q;
                s2_exp_q  <= exp_d;
                s2_norm_q <= norm_d;
            end
            if (s3_en) begin
                out_valid_q <= s2_valid_q;
            end
            if (s2_move) begin
                float_q <= result_d;
            end
        end
    end

    assign float_out = float_q;
    assign out_valid = out_valid_q;
    assign in_flight = 2'(s1_valid_q) + 2'(s2_valid_q) + 2'(out_valid_q);

endmodule
